dii_packet_buffer: RTL
======================

DII_PACKET_BUFFER -- requirements
Module: dii_packet_buffer

Interface
REQ-001 Parameter DEPTH, default 16: flit storage entries; SHALL be a power of two, ≥2.
REQ-002 Parameter FULLPACKET, default 1: 1 = store-and-forward per packet; 0 = plain flit FIFO.
REQ-003 Port clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 Port rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port flit_in  dii_channel.slave (N=1): data 16, last 1, valid 1 in; ready 1 out.
REQ-006 Port flit_out  dii_channel.master (N=1): data 16, last 1, valid 1 out; ready 1 in.
REQ-007 Port count  output  $clog2(DEPTH)+1  flits currently stored.
REQ-008 Port packet_count  output  $clog2(DEPTH)+1  complete packets (last flit stored) currently held.

Function
REQ-009 Storage SHALL be DEPTH entries of 17 bits {last, data}, with write/read pointers wrapping modulo DEPTH.
REQ-010 Push SHALL occur on any cycle with flit_in.valid && flit_in.ready; pop on any cycle with flit_out.valid && flit_out.ready.
REQ-011 flit_in.ready SHALL be 1 iff count < DEPTH, driven from registered state only (no dependence on flit_out.ready).
REQ-012 No bypass: a flit pushed in cycle N SHALL be presented on flit_out no earlier than cycle N+1.
REQ-013 flit_out.data/last SHALL be the oldest stored entry (show-ahead); values are don't-care when flit_out.valid=0.
REQ-014 FULLPACKET=0: flit_out.valid = (count != 0).
REQ-015 FULLPACKET=1: flit_out.valid = (count != 0) && (packet_count != 0 || count == DEPTH).
REQ-016 The count == DEPTH term is the overflow escape: a packet longer than DEPTH SHALL drain cut-through, preventing deadlock.
REQ-017 count: +1 on push-only, -1 on pop-only, unchanged on simultaneous push and pop or on neither.
REQ-018 packet_count: +1 when the pushed flit has last=1, -1 when the popped flit has last=1; both in the same cycle leave it unchanged.
REQ-019 Once flit_out.valid=1, it and flit_out.data/last SHALL remain stable until the pop handshake.
REQ-020 Full (count == DEPTH) with flit_out.ready=1: pop occurs, no push that cycle; flit_in.ready=1 the next cycle.
REQ-021 Empty with flit_in.valid=1: push occurs, flit_out.valid=0 that cycle.
REQ-022 Flits SHALL never be dropped, duplicated or reordered; packet boundaries (last) SHALL be preserved bit-exactly.
REQ-023 count and packet_count SHALL never exceed DEPTH or underflow below 0.

Reset
REQ-024 While rst_n=0: pointers, count and packet_count SHALL be 0; flit_out.valid=0; flit_in.ready=0.
REQ-025 Reset assertion mid-packet SHALL discard all stored flits immediately (asynchronously); storage contents need no reset.
REQ-026 First rising clk edge after rst_n deassertion: flit_in.ready=1, flit_out.valid=0.

Verification
REQ-027 DEPTH=4, FULLPACKET=1; push 3 flits 0x0001,0x0002,0x0003(last), flit_out.ready=1 -> flit_out.valid stays 0 until the cycle after the last push, then 3 flits in order, last only on 0x0003; packet_count 1->0.
REQ-028 DEPTH=4, FULLPACKET=1; 6-flit packet, flit_out.ready=1 -> after 4 pushes count=4, flit_in.ready=0, flit_out.valid=1; all 6 flits delivered in order, no loss.
REQ-029 DEPTH=4, FULLPACKET=0; continuous push and pop every cycle -> each flit appears 1 cycle after push; count holds steady at 1.
REQ-030 Full buffer, flit_out.ready toggled 1/0 per cycle, flit_in.valid=1 -> no overflow; count never exceeds 4; output stable while stalled.
REQ-031 Two 1-flit packets (last=1) pushed back-to-back while one pops -> packet_count increments/decrements correctly, unchanged on coincident last push and pop.
REQ-032 rst_n pulsed low mid-packet with count=3 -> count=0, packet_count=0, flit_out.valid=0 immediately; new packet after reset delivered correctly.

Source files
------------

// File: rtl/dii_packet_buffer_if.sv
// DII flit channel: a data word, a packet-end marker, and a valid/ready handshake.
// The master drives data/last/valid; the slave answers with ready.
interface dii_channel #(
  parameter int DW = 16
);
  logic [DW-1:0] data;
  logic          last;
  logic          valid;
  logic          ready;

  modport master (output data, last, valid, input ready);
  modport slave  (input data, last, valid, output ready);
endinterface

// File: rtl/dii_packet_buffer.sv
// Flit buffer that optionally holds flits back until a whole packet is stored.
// When FULLPACKET=1, a full buffer with no complete packet drains cut-through so long packets cannot deadlock.
module dii_packet_buffer #(
  parameter int DEPTH      = 16,
  parameter int FULLPACKET = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  dii_channel.slave              flit_in,
  dii_channel.master             flit_out,
  output logic [$clog2(DEPTH):0] count,
  output logic [$clog2(DEPTH):0] packet_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [16:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wrPtr;
  logic [AW-1:0] r_rdPtr;
  logic [CW-1:0] r_count;
  logic [CW-1:0] r_pktCount;
  logic          r_active;

  logic          w_full;
  logic          w_empty;
  logic          w_valid;
  logic          w_push;
  logic          w_pop;
  logic          w_pushLast;
  logic          w_popLast;
  logic [16:0]   w_head;

  assign w_full  = (r_count == FULL_COUNT);
  assign w_empty = (r_count == '0);
  assign w_head  = r_mem[r_rdPtr];

  // The full-buffer term releases a packet that cannot fit before its last flit arrives
  assign w_valid = (FULLPACKET != 0) ? (!w_empty && ((r_pktCount != '0) || w_full))
                                     : !w_empty;

  // r_active keeps ready low during reset and until the first clock edge afterwards
  assign flit_in.ready  = r_active && !w_full;
  assign flit_out.valid = w_valid;
  assign flit_out.data  = w_head[15:0];
  assign flit_out.last  = w_head[16];

  assign w_push     = flit_in.valid && flit_in.ready;
  assign w_pop      = w_valid && flit_out.ready;
  assign w_pushLast = w_push && flit_in.last;
  assign w_popLast  = w_pop && w_head[16];

  assign count        = r_count;
  assign packet_count = r_pktCount;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wrPtr] <= {flit_in.last, flit_in.data};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wrPtr    <= '0;
      r_rdPtr    <= '0;
      r_count    <= '0;
      r_pktCount <= '0;
      r_active   <= 1'b0;
    end else begin
      r_active <= 1'b1;
      if (w_push) begin
        r_wrPtr <= r_wrPtr + AW'(1);
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      case ({w_pushLast, w_popLast})
        2'b10:   r_pktCount <= r_pktCount + CW'(1);
        2'b01:   r_pktCount <= r_pktCount - CW'(1);
        default: r_pktCount <= r_pktCount;
      endcase
    end
  end
endmodule
